// File: rtl/dm9000_pkg.sv
// Shared DM9000 bus definitions: sequencer state encoding and default timing,
// also used by the Wishbone bridge and the packet DMA engine.
package dm9000_pkg;

  typedef enum logic [2:0] {
    DM_RST   = 3'd0,
    DM_IDLE  = 3'd1,
    DM_SETUP = 3'd2,
    DM_PULSE = 3'd3,
    DM_HOLD  = 3'd4,
    DM_RECOV = 3'd5
  } dm_state_e;

  localparam int DM_DW      = 16;
  localparam int DM_CNT_W   = 4;
  localparam int DM_T_SETUP = 1;
  localparam int DM_T_PULSE = 3;
  localparam int DM_T_HOLD  = 1;
  localparam int DM_T_RECOV = 2;
  localparam int DM_RST_CYC = 10;

endpackage

// File: rtl/dm9000_sync2.sv
// Two-flop synchroniser bringing the asynchronous DM9000 interrupt into the bus clock domain.
module dm9000_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/dm9000_bus_arb.sv
// DM9000 host-bus sequencer: round-robin grant between the CPU bridge (port 0) and
// the packet DMA (port 1), CS#/IOR#/IOW# phase timing and the chip reset sequence.
module dm9000_bus_arb
  import dm9000_pkg::*;
#(
  parameter int DM9000_DW = DM_DW,
  parameter int CNT_W     = DM_CNT_W,
  parameter int T_SETUP   = DM_T_SETUP,
  parameter int T_PULSE   = DM_T_PULSE,
  parameter int T_HOLD    = DM_T_HOLD,
  parameter int T_RECOV   = DM_T_RECOV,
  parameter int RST_CYC   = DM_RST_CYC
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic [1:0]           req_i,
  input  logic [1:0]           we_i,
  input  logic [1:0]           cmd_i,
  input  logic [DM9000_DW-1:0] wdata0_i,
  input  logic [DM9000_DW-1:0] wdata1_i,
  output logic [1:0]           done_o,
  output logic [DM9000_DW-1:0] rdata0_o,
  output logic [DM9000_DW-1:0] rdata1_o,
  output logic                 dm9000_cs_n,
  output logic                 dm9000_ior_n,
  output logic                 dm9000_iow_n,
  output logic                 dm9000_rst_n,
  output logic                 dm9000_cmd,
  output logic [DM9000_DW-1:0] dm9000_outdata,
  output logic                 dm9000_oe,
  input  logic [DM9000_DW-1:0] dm9000_indata,
  input  logic                 dm9000_intr,
  output logic                 irq_o,
  output dm_state_e            dbg_state_o
);

  // Phase lengths are loaded as T-1 so a phase ends when the counter reads zero.
  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] L_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] L_RECOV = CNT_W'(T_RECOV - 1);
  localparam logic [CNT_W-1:0] L_RST   = CNT_W'(RST_CYC - 1);

  dm_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                 r_ptr, r_port, r_we, r_cmd;
  logic [DM9000_DW-1:0] r_wdata, r_capt;
  logic                 w_grant, w_win, w_port, w_we, w_cmd, w_active, w_last_pulse;
  logic [DM9000_DW-1:0] w_wdata, w_rd_src;
  logic                 w_cs_n_nxt, w_ior_n_nxt, w_iow_n_nxt, w_rst_n_nxt, w_cmd_nxt, w_oe_nxt;
  logic [DM9000_DW-1:0] w_outdata_nxt;
  logic [1:0]           w_done_nxt;
  logic                 r_cs_n, r_ior_n, r_iow_n, r_rst_n, r_cmd_o, r_oe;
  logic [DM9000_DW-1:0] r_outdata, r_rdata0, r_rdata1;
  logic [1:0]           r_done;

  // Handshake: a port raises req_i with stable we/cmd/wdata and holds it until its
  // one-cycle done_o pulse; the pulse is the only acknowledgement of that request.
  assign w_grant = (r_state == DM_IDLE) && (|req_i);
  assign w_win   = (&req_i) ? r_ptr : req_i[1];
  assign w_port  = w_grant ? w_win : r_port;
  assign w_we    = w_grant ? we_i[w_win] : r_we;
  assign w_cmd   = w_grant ? cmd_i[w_win] : r_cmd;
  assign w_wdata = w_grant ? (w_win ? wdata1_i : wdata0_i) : r_wdata;

  assign w_last_pulse = (r_state == DM_PULSE) && (r_cnt == '0);
  assign w_rd_src     = w_last_pulse ? dm9000_indata : r_capt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= DM_RST;
      r_cnt   <= L_RST;
      r_ptr   <= 1'b0;
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_cmd   <= 1'b0;
      r_wdata <= '0;
      r_capt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_grant) begin
        r_ptr   <= ~w_win;
        r_port  <= w_win;
        r_we    <= w_we;
        r_cmd   <= w_cmd;
        r_wdata <= w_wdata;
      end
      if (w_last_pulse) r_capt <= dm9000_indata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CNT_W'(1) : '0;
    case (r_state)
      DM_RST:   if (r_cnt == '0) w_state_nxt = DM_IDLE;
      DM_IDLE:  if (|req_i) begin w_state_nxt = DM_SETUP; w_cnt_nxt = L_SETUP; end
      DM_SETUP: if (r_cnt == '0) begin w_state_nxt = DM_PULSE; w_cnt_nxt = L_PULSE; end
      DM_PULSE: if (r_cnt == '0) begin w_state_nxt = DM_HOLD;  w_cnt_nxt = L_HOLD;  end
      DM_HOLD:  if (r_cnt == '0) begin w_state_nxt = DM_RECOV; w_cnt_nxt = L_RECOV; end
      DM_RECOV: if (r_cnt == '0) w_state_nxt = DM_IDLE;
      default:  begin w_state_nxt = DM_RST; w_cnt_nxt = L_RST; end
    endcase
  end

  // Pin values are decoded from the next state so every chip pin leaves a flop.
  always_comb begin
    w_active      = (w_state_nxt == DM_SETUP) || (w_state_nxt == DM_PULSE) ||
                    (w_state_nxt == DM_HOLD);
    w_cs_n_nxt    = ~w_active;
    w_ior_n_nxt   = ~((w_state_nxt == DM_PULSE) && !w_we);
    w_iow_n_nxt   = ~((w_state_nxt == DM_PULSE) && w_we);
    w_oe_nxt      = w_active && w_we;
    w_outdata_nxt = (w_active && w_we) ? w_wdata : '0;
    w_cmd_nxt     = w_active && w_cmd;
    w_rst_n_nxt   = (w_state_nxt != DM_RST);
    w_done_nxt    = 2'b00;
    if ((w_state_nxt == DM_HOLD) && (w_cnt_nxt == '0)) w_done_nxt = w_port ? 2'b10 : 2'b01;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_cs_n    <= 1'b1;
      r_ior_n   <= 1'b1;
      r_iow_n   <= 1'b1;
      r_rst_n   <= 1'b0;
      r_cmd_o   <= 1'b0;
      r_oe      <= 1'b0;
      r_outdata <= '0;
      r_done    <= 2'b00;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_cs_n    <= w_cs_n_nxt;
      r_ior_n   <= w_ior_n_nxt;
      r_iow_n   <= w_iow_n_nxt;
      r_rst_n   <= w_rst_n_nxt;
      r_cmd_o   <= w_cmd_nxt;
      r_oe      <= w_oe_nxt;
      r_outdata <= w_outdata_nxt;
      r_done    <= w_done_nxt;
      if ((w_done_nxt != 2'b00) && !w_we) begin
        if (w_port) r_rdata1 <= w_rd_src;
        else        r_rdata0 <= w_rd_src;
      end
    end
  end

  dm9000_sync2 u_irq_sync (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_n_i),
    .i_d     (dm9000_intr),
    .o_q     (irq_o)
  );

  assign done_o         = r_done;
  assign rdata0_o       = r_rdata0;
  assign rdata1_o       = r_rdata1;
  assign dm9000_cs_n    = r_cs_n;
  assign dm9000_ior_n   = r_ior_n;
  assign dm9000_iow_n   = r_iow_n;
  assign dm9000_rst_n   = r_rst_n;
  assign dm9000_cmd     = r_cmd_o;
  assign dm9000_oe      = r_oe;
  assign dm9000_outdata = r_outdata;
  assign dbg_state_o    = r_state;

endmodule

// File: doc/dm9000_bus_arb.md
# dm9000_bus_arb

Sequencer and arbiter for the DM9000 16-bit host bus, shared between two requesters. Port 0 is the CPU Wishbone bridge and port 1 is the packet DMA engine. The block grants the bus round-robin, generates CS#/CMD/IOR#/IOW# with parameterised setup, pulse, hold and recovery times, and runs the chip reset sequence. It also synchronises the chip interrupt. It sits between the requesters and the board-level DM9000 pins; tri-state buffering is done at top level.

## Interface
- `DM9000_DW`, 16: chip data width
- `CNT_W`, 4: width of the phase counter
- `T_SETUP`, 1: cycles with CS#/CMD valid before the strobe (≥1)
- `T_PULSE`, 3: strobe-low cycles (≥1)
- `T_HOLD`, 1: cycles after the strobe rises, with CS# still low (≥1)
- `T_RECOV`, 2: cycles with CS# high between accesses (≥1)
- `RST_CYC`, 10: cycles `dm9000_rst_n` is held low after reset release (≥1)

Ports (one clock; reset is asynchronous and active-low):
- `wb_clk_i`  in  1  clock
- `wb_rst_n_i`  in  1  asynchronous active-low reset
- `req_i`  in  2  per-port request; held high until that port's `done_o`
- `we_i`  in  2  per-port write (1) / read (0)
- `cmd_i`  in  2  per-port CMD pin value (0 = index, 1 = data)
- `wdata0_i`, `wdata1_i`  in  DM9000_DW  write data
- `done_o`  out  2  one-cycle completion pulse per port
- `rdata0_o`, `rdata1_o`  out  DM9000_DW  read data, held until that port's next read completes
- `dm9000_cs_n`, `dm9000_ior_n`, `dm9000_iow_n`, `dm9000_rst_n`, `dm9000_cmd`  out  1  chip controls
- `dm9000_outdata`  out  DM9000_DW  write data to the pad
- `dm9000_oe`  out  1  pad output enable
- `dm9000_indata`  in  DM9000_DW  read data from the pad
- `dm9000_intr`  in  1  chip interrupt (asynchronous)
- `irq_o`  out  1  synchronised interrupt

## Operation
- **States:** RST → IDLE → SETUP → PULSE → HOLD → RECOV → IDLE. All outputs are registered.
- **RST:** `dm9000_rst_n` = 0 for RST_CYC cycles, then goes to 1 and the block enters IDLE. Requests arriving in RST stay pending; none are granted.
- **IDLE:** if any `req_i` bit is set, grant one port and move to SETUP. Latch the winner's `we`, `cmd` and `wdata`. Requester fields must stay stable while its `req_i` is high.
- **Arbitration:** round-robin priority pointer, reset to port 0. When both ports request, the port at the pointer wins. The pointer moves to the other port after each grant. A lone requester always wins.
- **SETUP:** `cs_n` = 0, `cmd` = latched value, `oe` = `we`, `outdata` = `wdata` on writes.
- **PULSE:** `ior_n` (read) or `iow_n` (write) = 0. Read data is sampled on the clock edge that ends the last PULSE cycle.
- **HOLD:** strobe high; `cs_n`, `cmd`, `outdata` and `oe` unchanged. `done_o[port]` is high in the last HOLD cycle; `rdataN_o` is valid from that cycle.
- **RECOV:** `cs_n` = 1, `oe` = 0. A requester samples `done_o` and drops or re-raises `req_i` here.
- **Phase counter:** one counter of CNT_W bits, loaded with T_x−1 on phase entry; the phase ends at 0. Every T_x parameter must be < 2^CNT_W.
- **Interrupt:** two-flop synchroniser, `dm9000_intr` → `irq_o`.

## Timing
- **Reset values:** `cs_n`/`ior_n`/`iow_n` = 1, `rst_n` = 0, `cmd` = 0, `oe` = 0, `outdata` = 0, `done_o` = 0, `rdata*` = 0, `irq_o` = 0, pointer = 0, state = RST.
- **Access timeline:** req seen in IDLE at cycle 0. SETUP occupies cycles 1..Ts, PULSE Ts+1..Ts+Tp, HOLD Ts+Tp+1..Ts+Tp+Th. `done_o` is high in cycle Ts+Tp+Th (default 5).
- **Back-to-back:** the next SETUP starts at cycle Ts+Tp+Th+Tr+2 (default 9).
- **Reset mid-access:** asynchronous assertion forces all reset values immediately, with no `done_o` for the aborted access. On release, the full RST sequence runs again.
- **Reset release:** `dm9000_rst_n` rises at cycle RST_CYC after release.
- **Interrupt latency:** `irq_o` follows `dm9000_intr` with 2–3 cycles of latency.

## Structure
- **Shared package `dm9000_pkg`:** state enum (`DM_RST`, `DM_IDLE`, `DM_SETUP`, `DM_PULSE`, `DM_HOLD`, `DM_RECOV`) and default timing constants. These are shared with the Wishbone bridge and the DMA engine.
- **Sub-module `dm9000_sync2`:** 2-flop synchroniser for `dm9000_intr`.

## Test plan
- **Reset sequence:** release reset with `req_i` = 01 → `dm9000_rst_n` low for 10 cycles, then the first SETUP starts the cycle after IDLE is reached.
- **Port 0 write:** `cmd` = 1, `wdata0` = 16'hA55A → `cs_n` low for 5 cycles, `iow_n` low for exactly 3, `outdata` = A55A with `oe` = 1 throughout, `done_o` = 01 in cycle 5.
- **Port 1 read:** `dm9000_indata` = 16'h1234 during PULSE → `rdata1_o` = 1234 when `done_o` = 10, held through a later port-0 read of 16'hBEEF.
- **Contention:** `req_i` = 11 from reset → grants go 0, 1, 0, 1; SETUP starts are 9 cycles apart; `done_o` is never 11.
- **Reset abort:** reset asserted in the second PULSE cycle → all strobes high in the same cycle, no `done_o`; after release, RST runs again.
- **Interrupt sync:** `dm9000_intr` pulsed high for 4 cycles → `irq_o` high for 4 cycles, delayed by 2.
